demux_slot_sequencer: RTL and testbench

- Upstream control stage for the 1-to-4 demultiplexer (demux_1_4).
- Drives the demux select pair (s1, s0) and its enable (en), so that each of four requesting channels gets a fixed-length enable slot in round-robin order.
- Guarantees break-before-make: select lines change only while en is low, so the combinational demux never glitches an unselected output.

---
 rtl/demux_seq_pkg.sv | 21 ++
 rtl/rr_pick.sv | 27 ++
 rtl/demux_slot_sequencer.sv | 100 ++++++++++
 tb/tb_demux_slot_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the demux slot sequencer.
package demux_seq_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Registered control word presented to the demux and its observers.
    typedef struct packed {
        logic [CH_W-1:0] sel;
        logic            en;
        logic            busy;
        logic            slot_done;
    } slot_out_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit after ptr, wrapping around.
module rr_pick
    import demux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   next,
    output logic              valid
);

    logic [CH_W-1:0] cand;

    // Scan farthest-first so the nearest set bit after ptr wins last.
    always_comb begin
        next  = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = ptr + CH_W'(k);
            if (req[cand]) begin
                next  = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_slot_sequencer.sv
// Round-robin slot sequencer driving a 1-to-4 demux with break-before-make.
module demux_slot_sequencer
    import demux_seq_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [NUM_CH-1:0] req,
    output logic              s1,
    output logic              s0,
    output logic              en,
    output logic              busy,
    output logic              slot_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t          state, state_nx;
    slot_out_t       out_q, out_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [CH_W-1:0] ptr, ptr_nx;
    logic [CH_W-1:0] pick;
    logic            pick_valid;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .next  (pick),
        .valid (pick_valid)
    );

    // State, counter, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_q <= '0;
            count <= '0;
            ptr   <= CH_W'(NUM_CH - 1);
        end else begin
            state <= state_nx;
            out_q <= out_nx;
            count <= count_nx;
            ptr   <= ptr_nx;
        end
    end

    // Next-state and next-output logic; select only moves on IDLE->LOAD.
    always_comb begin
        state_nx         = state;
        count_nx         = count;
        ptr_nx           = ptr;
        out_nx           = '0;
        out_nx.sel       = out_q.sel;

        unique case (state)
            IDLE: begin
                if (run && pick_valid) begin
                    out_nx.sel = pick;
                    ptr_nx     = pick;
                    state_nx   = LOAD;
                end
            end
            LOAD: begin
                if (run && req[out_q.sel]) begin
                    state_nx  = ACTIVE;
                    out_nx.en = 1'b1;
                    count_nx  = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            ACTIVE: begin
                if (!run || !req[out_q.sel]) begin
                    state_nx = IDLE;
                end else if (count == LAST) begin
                    state_nx         = IDLE;
                    out_nx.slot_done = 1'b1;
                end else begin
                    out_nx.en = 1'b1;
                    count_nx  = count + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        out_nx.busy = (state_nx != IDLE);
    end

    assign s1        = out_q.sel[1];
    assign s0        = out_q.sel[0];
    assign en        = out_q.en;
    assign busy      = out_q.busy;
    assign slot_done = out_q.slot_done;

endmodule

// File: tb/tb_demux_slot_sequencer.sv
// Self-checking bench: timeline tables replayed through a scoreboard queue.
module tb_demux_slot_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run_a, run_b;
    logic [3:0] req_a, req_b;
    logic       s1_a, s0_a, en_a, busy_a, done_a;
    logic       s1_b, s0_b, en_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    demux_slot_sequencer #(.DWELL(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run_a), .req(req_a),
        .s1(s1_a), .s0(s0_a), .en(en_a), .busy(busy_a), .slot_done(done_a)
    );

    demux_slot_sequencer #(.DWELL(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run_b), .req(req_b),
        .s1(s1_b), .s0(s0_b), .en(en_b), .busy(busy_b), .slot_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record: inputs driven before an edge, outputs expected after it.
    typedef struct {
        string      tag;
        bit         b;
        logic       run;
        logic [3:0] req;
        logic [1:0] sel;
        logic       en;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs_t1[$];
    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(string tag, bit b, logic r, logic [3:0] q,
                                logic [1:0] sel, logic e, logic bz, logic d);
        vec_t v;
        v.tag = tag; v.b = b; v.run = r; v.req = q;
        v.sel = sel; v.en = e; v.busy = bz; v.done = d;
        return v;
    endfunction

    // Expected timeline of one complete slot: LOAD, DWELL cycles of en, IDLE+done.
    function automatic void add_slot(string tag, bit b, logic [3:0] q,
                                     logic [1:0] ch, int dwell);
        vecs.push_back(mk(tag, b, 1'b1, q, ch, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < dwell; i++)
            vecs.push_back(mk(tag, b, 1'b1, q, ch, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(tag, b, 1'b1, q, ch, 1'b0, 1'b0, 1'b1));
    endfunction

    function automatic logic [4:0] outs(bit b);
        return b ? {s1_b, s0_b, en_b, busy_b, done_b}
                 : {s1_a, s0_a, en_a, busy_a, done_a};
    endfunction

    task automatic chk(string tag, logic [4:0] got, logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {sel,en,busy,done}=%b_%b_%b_%b expected %b_%b_%b_%b",
                     tag, got[4:3], got[2], got[1], got[0],
                     exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        if (v.b) begin run_b = v.run; req_b = v.req; end
        else     begin run_a = v.run; req_a = v.req; end
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, outs(e.b), {e.sel, e.en, e.busy, e.done});
    endtask

    // Select must never move between two consecutive en-high samples.
    logic       prev_en_a, prev_en_b;
    logic [1:0] prev_sel_a, prev_sel_b;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (prev_en_a && en_a) begin
                checks++;
                if ({s1_a, s0_a} !== prev_sel_a) begin
                    failures++;
                    $display("FAIL bbm_a: sel changed %b -> %b while en high",
                             prev_sel_a, {s1_a, s0_a});
                end
            end
            if (prev_en_b && en_b) begin
                checks++;
                if ({s1_b, s0_b} !== prev_sel_b) begin
                    failures++;
                    $display("FAIL bbm_b: sel changed %b -> %b while en high",
                             prev_sel_b, {s1_b, s0_b});
                end
            end
            prev_en_a = en_a; prev_sel_a = {s1_a, s0_a};
            prev_en_b = en_b; prev_sel_b = {s1_b, s0_b};
        end else begin
            prev_en_a = 1'b0;
            prev_en_b = 1'b0;
        end
    end

    initial begin
        prev_en_a = 1'b0; prev_en_b = 1'b0;
        prev_sel_a = '0;  prev_sel_b = '0;
        rst_n = 1'b0;
        run_a = 1'b0; req_a = '0;
        run_b = 1'b0; req_b = '0;

        // Test 1 prelude: single requester ch0 right after reset release.
        vecs_t1.push_back(mk("t1_load", 0, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0));
        vecs_t1.push_back(mk("t1_en",   0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0));
        vecs_t1.push_back(mk("t1_en2",  0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0));

        // Test 2: all requesting, ptr starts at 3 so order is 0,1,2,3,0.
        add_slot("t2_ch0", 0, 4'b1111, 2'd0, 4);
        add_slot("t2_ch1", 0, 4'b1111, 2'd1, 4);
        add_slot("t2_ch2", 0, 4'b1111, 2'd2, 4);
        add_slot("t2_ch3", 0, 4'b1111, 2'd3, 4);
        add_slot("t2_ch0b", 0, 4'b1111, 2'd0, 4);
        // Test 3: req=1010 after ptr=0 -> 1, 3, 1.
        add_slot("t3_ch1", 0, 4'b1010, 2'd1, 4);
        add_slot("t3_ch3", 0, 4'b1010, 2'd3, 4);
        add_slot("t3_ch1b", 0, 4'b1010, 2'd1, 4);
        // Test 4: run drops in the 2nd ACTIVE cycle of the ch3 slot.
        vecs.push_back(mk("t4_load", 0, 1'b1, 4'b1010, 2'd3, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("t4_act1", 0, 1'b1, 4'b1010, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("t4_act2", 0, 1'b1, 4'b1010, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("t4_abort", 0, 1'b0, 4'b1010, 2'd3, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("t4_idle", 0, 1'b0, 4'b1010, 2'd3, 1'b0, 1'b0, 1'b0));
        // Test 5: granted bit withdrawn in LOAD, then no requests at all.
        vecs.push_back(mk("t5_load", 0, 1'b1, 4'b1010, 2'd1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("t5_drop", 0, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("t5_idle", 0, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0));
        // Test 6: DWELL=1 instance, ch2 only, period 3.
        add_slot("t6_ch2a", 1, 4'b0100, 2'd2, 1);
        add_slot("t6_ch2b", 1, 4'b0100, 2'd2, 1);
        add_slot("t6_ch2c", 1, 4'b0100, 2'd2, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", outs(0), 5'b00000);
        chk("reset_b", outs(1), 5'b00000);
        rst_n = 1'b1;

        foreach (vecs_t1[i]) apply(vecs_t1[i]);

        // Asynchronous reset mid-slot: outputs clear with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", outs(0), 5'b00000);
        chk("async_rst_b", outs(1), 5'b00000);
        @(posedge clk);
        #1;
        chk("held_rst_a", outs(0), 5'b00000);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].b && vecs[i].tag == "t6_ch2a" && !run_b)
                chk("b_idle_before_t6", outs(1), 5'b00000);
            apply(vecs[i]);
        end

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
